// File: rtl/gate_stim_pkg.sv
// Shared types and reference truth tables for the gate stimulus checker.
// Truth tables are indexed by {A,B}: bit 0 is A=0,B=0 and bit 3 is A=1,B=1.
package gate_stim_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;

    localparam logic [1:0] LAST_IDX = 2'd3;

endpackage

// File: rtl/gate_stim_checker_hold_counter.sv
// Dwell counter: counts enabled cycles, flags the last one of each HOLD_CYCLES window, rolls to 0.
// Terminal flag is combinational from the count register; clear wins over enable, never stalls.
module hold_counter #(
    parameter int HOLD_CYCLES = 20,
    parameter int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc_o = (cnt_q == CNT_W'(HOLD_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            // Roll over on the sample cycle so the next combination starts a fresh window.
            cnt_d = tc_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gate_stim_checker.sv
// Sweeps {A,B} through 00..11, holding each HOLD_CYCLES cycles, and scores O against TRUTH; sweep takes 4*HOLD_CYCLES cycles.
// No backpressure: start is honoured only in IDLE/DONE and dropped while busy; all outputs are registered.
module gate_stim_checker
    import gate_stim_pkg::*;
#(
    parameter int         HOLD_CYCLES = 20,
    parameter logic [3:0] TRUTH       = TT_NOR
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       A,
    output logic       B,
    input  logic       O,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    state_t     state_q;
    logic [1:0] idx_q;
    logic [1:0] idx_d;
    logic       a_q;
    logic       b_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic [2:0] err_q;
    logic [2:0] err_d;
    logic [3:0] fail_q;
    logic       hold_tc;
    logic       mismatch;
    logic       in_drive;

    assign in_drive = (state_q == DRIVE);
    assign idx_d    = idx_q + 2'd1;
    assign err_d    = err_q + 3'd1;

    // Anything other than a clean match (including X/Z from the gate) is scored as an error.
    assign mismatch = (O === TRUTH[idx_q]) ? 1'b0 : 1'b1;

    hold_counter #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (!in_drive),
        .en_i  (in_drive),
        .tc_o  (hold_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 3'd0;
            fail_q  <= 4'd0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= DRIVE;
                        idx_q   <= 2'd0;
                        a_q     <= 1'b0;
                        b_q     <= 1'b0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        err_q   <= 3'd0;
                        fail_q  <= 4'd0;
                    end
                end
                DRIVE: begin
                    if (hold_tc) begin
                        if (mismatch) begin
                            err_q         <= err_d;
                            fail_q[idx_q] <= 1'b1;
                        end
                        if (idx_q == LAST_IDX) begin
                            // Stimulus stays at 11 so the last applied pattern is visible in DONE.
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_q == 3'd0) && !mismatch;
                        end else begin
                            idx_q <= idx_d;
                            a_q   <= idx_d[1];
                            b_q   <= idx_d[0];
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    pass_q  <= 1'b0;
                end
            endcase
        end
    end

    assign A         = a_q;
    assign B         = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fail_q;

    a_pass_implies_done: assert property (@(posedge clk) disable iff (!rst_n) pass_q |-> done_q);
    a_err_bounded:       assert property (@(posedge clk) disable iff (!rst_n) err_q <= 3'd4);
    a_busy_done_excl:    assert property (@(posedge clk) disable iff (!rst_n) !(busy_q && done_q));

endmodule

// File: tb/tb_gate_stim_checker.sv
// Randomized bench: two checkers (dwell 20 and dwell 1) driving a table-defined gate, scored against a sweep model.
module tb_gate_stim_checker;
    import gate_stim_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       sel;
    logic [3:0] gate_tt;

    logic       a20, b20, busy20, done20, pass20, o20;
    logic [2:0] err20;
    logic [3:0] fv20;
    logic       a1, b1, busy1, done1, pass1, o1;
    logic [2:0] err1;
    logic [3:0] fv1;

    logic       obs_a, obs_b, obs_busy, obs_done, obs_pass;
    logic [2:0] obs_err;
    logic [3:0] obs_fv;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign o20 = gate_tt[{a20, b20}];
    assign o1  = gate_tt[{a1, b1}];

    gate_stim_checker #(.HOLD_CYCLES(20), .TRUTH(TT_NOR)) dut20 (
        .clk(clk), .rst_n(rst_n), .start(start & ~sel), .A(a20), .B(b20), .O(o20),
        .busy(busy20), .done(done20), .pass(pass20), .err_count(err20), .fail_vec(fv20)
    );

    gate_stim_checker #(.HOLD_CYCLES(1), .TRUTH(TT_NOR)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start & sel), .A(a1), .B(b1), .O(o1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_vec(fv1)
    );

    always_comb begin
        obs_a    = sel ? a1    : a20;
        obs_b    = sel ? b1    : b20;
        obs_busy = sel ? busy1 : busy20;
        obs_done = sel ? done1 : done20;
        obs_pass = sel ? pass1 : pass20;
        obs_err  = sel ? err1  : err20;
        obs_fv   = sel ? fv1   : fv20;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s sel=%0d t=%0t got=0x%0h exp=0x%0h", tag, sel, $time, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ab"},   {30'd0, obs_a, obs_b}, 32'd0);
        chk({tag, "_busy"}, {31'd0, obs_busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, obs_done}, 32'd0);
        chk({tag, "_pass"}, {31'd0, obs_pass}, 32'd0);
        chk({tag, "_err"},  {29'd0, obs_err},  32'd0);
        chk({tag, "_fv"},   {28'd0, obs_fv},   32'd0);
    endtask

    // One sweep: model says combination k/h is on the pins during DRIVE cycle k, and the verdict
    // is the set of table entries where the gate disagrees with NOR.
    task automatic sweep(input logic [3:0] tt, input bit stray, input int rst_at);
        int         h;
        int         n;
        int         bad;
        logic [3:0] exp_fv;
        h      = sel ? 1 : 20;
        n      = 4 * h;
        exp_fv = tt ^ TT_NOR;
        @(negedge clk);
        gate_tt = tt;
        start   = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            start = stray ? ($urandom_range(0, 3) == 0) : 1'b0;
            chk("busy", {31'd0, obs_busy}, 32'd1);
            chk("done_lo", {31'd0, obs_done}, 32'd0);
            chk("ab", {30'd0, obs_a, obs_b}, k / h);
            if (k == 0) begin
                chk("start_err", {29'd0, obs_err}, 32'd0);
                chk("start_fv", {28'd0, obs_fv}, 32'd0);
                chk("start_pass", {31'd0, obs_pass}, 32'd0);
            end
            if (k == rst_at) begin
                rst_n = 1'b0;
                start = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                chk_all_zero("abort");
                bad = 0;
                repeat (100) begin
                    @(negedge clk);
                    if (obs_done || obs_busy) bad++;
                end
                chk("abort_quiet", bad, 32'd0);
                return;
            end
        end
        @(negedge clk);
        start = 1'b0;
        chk("end_done", {31'd0, obs_done}, 32'd1);
        chk("end_busy", {31'd0, obs_busy}, 32'd0);
        chk("end_ab", {30'd0, obs_a, obs_b}, 32'd3);
        chk("end_err", {29'd0, obs_err}, $countones(exp_fv));
        chk("end_fv", {28'd0, obs_fv}, {28'd0, exp_fv});
        chk("end_pass", {31'd0, obs_pass}, {31'd0, (exp_fv == 4'd0)});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
        $fatal(1);
    end

    initial begin
        logic [3:0] tt;
        logic [2:0] held_err;
        logic [3:0] held_fv;
        int         gap;

        rst_n   = 1'b0;
        start   = 1'b0;
        sel     = 1'b0;
        gate_tt = TT_NOR;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk_all_zero("rst20");
        sel = 1'b1;
        chk_all_zero("rst1");
        sel = 1'b0;

        sweep(TT_NOR, 1'b0, -1);
        sweep(TT_OR, 1'b0, -1);
        sweep(4'b0000, 1'b0, -1);
        sweep(TT_NOR, 1'b0, 45);
        sweep(TT_NOR, 1'b0, -1);

        // start presented together with reset must be lost
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_all_zero("rst_start");
        @(negedge clk);
        chk("rst_start_idle", {31'd0, obs_busy}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            tt = 4'($urandom);
            sweep(tt, 1'b1, -1);
            held_err = obs_err;
            held_fv  = obs_fv;
            gap = $urandom_range(1, 15);
            repeat (gap) @(negedge clk);
            chk("hold_done", {31'd0, obs_done}, 32'd1);
            chk("hold_err", {29'd0, obs_err}, $countones(tt ^ TT_NOR));
            chk("hold_fv", {28'd0, obs_fv}, {28'd0, tt ^ TT_NOR});
            if (held_err !== obs_err || held_fv !== obs_fv) begin
                chk("hold_stable", {25'd0, obs_err, obs_fv}, {25'd0, held_err, held_fv});
            end
        end

        sel = 1'b1;
        sweep(TT_NOR, 1'b1, -1);
        sweep(TT_OR, 1'b1, -1);
        for (int i = 0; i < 24; i++) begin
            tt = 4'($urandom);
            sweep(tt, 1'b1, -1);
        end
        sweep(TT_XOR, 1'b0, 2);
        sweep(TT_AND, 1'b0, -1);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
